ysyx_24100006_wbu_commit: RTL and testbench

//  Write-back/commit stage; consumer end of the MEM_WB valid/ready interface. Accepts one retired

---
 rtl/ysyx_24100006_wbu_commit.sv | 118 +++++++++++
 tb/tb_ysyx_24100006_wbu_commit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_wbu_commit.sv
// ysyx_24100006_wbu_commit: write-back/commit stage with GPR write, machine CSRs, trap/mret redirect and ebreak halt
//   clk, reset (async active-low)                    clock / reset
//   in_valid, in_ready                               MEM_WB handshake
//   pc_i .. is_break_i                               retired instruction fields
//   gpr_wen, gpr_waddr, gpr_wdata                    regfile write port
//   csr_raddr, csr_rdata                             decode-stage CSR read port
//   flush_o, redirect_valid, redirect_pc             one-cycle flush + IFU redirect
//   commit_valid, commit_pc, commit_npc              registered difftest trace
//   halt_o                                           ebreak retired
module ysyx_24100006_wbu_commit #(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
    parameter int          CNT_W       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc_i,
    input  logic [31:0] npc_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] sext_imm_i,
    input  logic [31:0] Mem_rdata_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rdata_csr_i,
    input  logic [3:0]  Gpr_Write_Addr_i,
    input  logic        Gpr_Write_i,
    input  logic [2:0]  Gpr_Write_RD_i,
    input  logic [1:0]  Csr_Write_RD_i,
    input  logic [11:0] Csr_Write_Addr_i,
    input  logic        Csr_Write_i,
    input  logic        irq_i,
    input  logic [7:0]  irq_no_i,
    input  logic        is_mret_i,
    input  logic        is_break_i,
    output logic        gpr_wen,
    output logic [3:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        flush_o,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_npc,
    output logic        halt_o
);
    typedef enum logic [1:0] {RUN, TRAP, HALT} state_t;
    state_t state;
    logic [31:0] mstatus, mtvec, mepc, mcause;
    logic [31:0] csr_wdata, mstatus_nx, mtvec_nx, mepc_nx, mcause_nx, trap_pc;
    logic [CNT_W-1:0] minstret;
    logic [63:0] cnt;
    logic accept, csr_we, is_trap, is_mret, is_brk;
    // in_ready is gated by reset so nothing is accepted or written while reset is held
    assign in_ready = reset & (state == RUN);
    assign accept   = in_valid & in_ready;
    assign is_trap  = accept & irq_i;
    assign is_mret  = accept & ~irq_i & is_mret_i;
    assign is_brk   = accept & ~irq_i & ~is_mret_i & is_break_i;
    assign gpr_wen   = accept & Gpr_Write_i & (Gpr_Write_Addr_i != 4'd0) & ~irq_i & ~is_mret_i;
    assign gpr_waddr = Gpr_Write_Addr_i;
    assign gpr_wdata = Gpr_Write_RD_i == 3'd0 ? alu_result_i :
                       Gpr_Write_RD_i == 3'd1 ? Mem_rdata_i :
                       Gpr_Write_RD_i == 3'd2 ? sext_imm_i :
                       Gpr_Write_RD_i == 3'd3 ? pc_i + 32'd4 :
                       Gpr_Write_RD_i == 3'd4 ? rdata_csr_i : 32'd0;
    assign csr_we    = accept & Csr_Write_i;
    assign csr_wdata = Csr_Write_RD_i == 2'd1 ? rdata_csr_i | rs1_data_i :
                       Csr_Write_RD_i == 2'd2 ? rdata_csr_i & ~rs1_data_i : rs1_data_i;
    // CSR values after this instruction's own CSR write; trap/mret side effects apply on top
    assign mstatus_nx = csr_we && Csr_Write_Addr_i == 12'h300 ? csr_wdata : mstatus;
    assign mtvec_nx   = csr_we && Csr_Write_Addr_i == 12'h305 ? {csr_wdata[31:2], 2'b00} : mtvec;
    assign mepc_nx    = csr_we && Csr_Write_Addr_i == 12'h341 ? csr_wdata : mepc;
    assign mcause_nx  = csr_we && Csr_Write_Addr_i == 12'h342 ? csr_wdata : mcause;
    assign trap_pc    = is_trap ? mtvec_nx : mepc_nx;
    assign cnt        = 64'(minstret);
    assign csr_rdata = csr_raddr == 12'h300 ? mstatus :
                       csr_raddr == 12'h305 ? mtvec :
                       csr_raddr == 12'h341 ? mepc :
                       csr_raddr == 12'h342 ? mcause :
                       csr_raddr == 12'hB02 ? cnt[31:0] :
                       csr_raddr == 12'hB82 ? cnt[63:32] : 32'd0;
    assign flush_o        = state == TRAP;
    assign redirect_valid = state == TRAP;
    assign halt_o         = state == HALT;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            mstatus      <= MSTATUS_RST;
            mtvec        <= MTVEC_RST;
            mepc         <= 32'd0;
            mcause       <= 32'd0;
            minstret     <= '0;
            redirect_pc  <= 32'd0;
            commit_valid <= 1'b0;
            commit_pc    <= 32'd0;
            commit_npc   <= 32'd0;
        end else begin
            mtvec  <= mtvec_nx;
            mepc   <= is_trap ? pc_i : mepc_nx;
            mcause <= is_trap ? {24'd0, irq_no_i} : mcause_nx;
            // bit 7 = MPIE, bit 3 = MIE
            mstatus <= is_trap ? {mstatus_nx[31:8], mstatus_nx[3], mstatus_nx[6:4], 1'b0, mstatus_nx[2:0]} :
                       is_mret ? {mstatus_nx[31:8], 1'b1, mstatus_nx[6:4], mstatus_nx[7], mstatus_nx[2:0]} :
                       mstatus_nx;
            if (accept) minstret <= minstret + CNT_W'(1);
            if (is_trap | is_mret) redirect_pc <= trap_pc;
            commit_valid <= accept;
            if (accept) commit_pc <= pc_i;
            if (accept) commit_npc <= (is_trap | is_mret) ? trap_pc : npc_i;
            state <= state == TRAP ? RUN :
                     (is_trap | is_mret) ? TRAP :
                     is_brk ? HALT : state;
        end
    end
endmodule

// File: tb/tb_ysyx_24100006_wbu_commit.sv
// tb_ysyx_24100006_wbu_commit: scoreboard bench for the write-back/commit stage
module tb_ysyx_24100006_wbu_commit;
    logic clk = 1'b0, reset = 1'b0;
    always #10 clk = ~clk;
    logic        in_valid, in_ready;
    logic [31:0] pc_i, npc_i, alu_result_i, sext_imm_i, Mem_rdata_i, rs1_data_i, rdata_csr_i;
    logic [3:0]  Gpr_Write_Addr_i;
    logic        Gpr_Write_i;
    logic [2:0]  Gpr_Write_RD_i;
    logic [1:0]  Csr_Write_RD_i;
    logic [11:0] Csr_Write_Addr_i;
    logic        Csr_Write_i, irq_i, is_mret_i, is_break_i;
    logic [7:0]  irq_no_i;
    logic        gpr_wen;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [11:0] csr_raddr = 12'h0;
    logic [31:0] csr_rdata;
    logic        flush_o, redirect_valid, commit_valid, halt_o;
    logic [31:0] redirect_pc, commit_pc, commit_npc;
    ysyx_24100006_wbu_commit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .npc_i(npc_i), .alu_result_i(alu_result_i), .sext_imm_i(sext_imm_i),
        .Mem_rdata_i(Mem_rdata_i), .rs1_data_i(rs1_data_i), .rdata_csr_i(rdata_csr_i),
        .Gpr_Write_Addr_i(Gpr_Write_Addr_i), .Gpr_Write_i(Gpr_Write_i), .Gpr_Write_RD_i(Gpr_Write_RD_i),
        .Csr_Write_RD_i(Csr_Write_RD_i), .Csr_Write_Addr_i(Csr_Write_Addr_i), .Csr_Write_i(Csr_Write_i),
        .irq_i(irq_i), .irq_no_i(irq_no_i), .is_mret_i(is_mret_i), .is_break_i(is_break_i),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .flush_o(flush_o),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_npc(commit_npc), .halt_o(halt_o)
    );
    int runs = 0, fails = 0;
    logic [35:0] gq[$];
    logic [63:0] cq[$];
    logic [35:0] ge;
    logic [63:0] ce;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        runs++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic csr_chk(input string n, input logic [11:0] a, input logic [31:0] e);
        csr_raddr = a;
        #1;
        chk(n, 64'(csr_rdata), 64'(e));
    endtask
    task automatic clr();
        in_valid = 0; pc_i = 0; npc_i = 0; alu_result_i = 0; sext_imm_i = 0; Mem_rdata_i = 0;
        rs1_data_i = 0; rdata_csr_i = 0; Gpr_Write_Addr_i = 0; Gpr_Write_i = 0; Gpr_Write_RD_i = 0;
        Csr_Write_RD_i = 0; Csr_Write_Addr_i = 0; Csr_Write_i = 0; irq_i = 0; irq_no_i = 0;
        is_mret_i = 0; is_break_i = 0;
    endtask
    task automatic align();
        @(posedge clk);
        #1;
    endtask
    // Presents the current fields, waits (bounded) for in_ready, records expectations, retires on the next edge
    task automatic go(input bit eg, input logic [3:0] ea, input logic [31:0] ed, input logic [31:0] en, output int st);
        int n = 0;
        in_valid = 1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        st = n;
        if (!in_ready) begin
            runs++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed %b after %0d cycles, required 1", in_ready, n);
        end
        if (eg) gq.push_back({ea, ed});
        cq.push_back({pc_i, en});
        @(posedge clk);
        #1;
        clr();
    endtask
    always @(negedge clk) begin
        if (reset) begin
            if (gpr_wen) begin
                if (gq.size() == 0) begin
                    runs++;
                    fails++;
                    $display("FAIL gpr_unexpected: got write %h<=%h, required no write", gpr_waddr, gpr_wdata);
                end else begin
                    ge = gq.pop_front();
                    chk("gpr_write", 64'({gpr_waddr, gpr_wdata}), 64'(ge));
                end
            end
            if (commit_valid) begin
                if (cq.size() == 0) begin
                    runs++;
                    fails++;
                    $display("FAIL commit_unexpected: got pc %h npc %h, required no commit", commit_pc, commit_npc);
                end else begin
                    ce = cq.pop_front();
                    chk("commit", {commit_pc, commit_npc}, ce);
                end
            end
        end
    end
    logic [31:0] exp_sel[8];
    int st;
    initial begin
        clr();
        exp_sel = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0, 32'h4444_4444, 32'h0, 32'h0, 32'h0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_redirect_pc", 64'(redirect_pc), 0);
        reset = 1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 1);
        chk("rel_outs", 64'({flush_o, redirect_valid, commit_valid, halt_o, gpr_wen}), 0);
        csr_chk("rst_mstatus", 12'h300, 32'h1800);
        csr_chk("rst_mtvec", 12'h305, 32'h0);
        csr_chk("rst_minstret", 12'hB02, 32'h0);
        align();
        // 1: addi rd=5
        pc_i = 32'h8000_0000; npc_i = 32'h8000_0004; Gpr_Write_i = 1; Gpr_Write_Addr_i = 5;
        alu_result_i = 32'h1234;
        go(1, 4'd5, 32'h1234, 32'h8000_0004, st);
        csr_chk("minstret_1", 12'hB02, 32'd1);
        align();
        // 2: every data select, pc+4 wraps to 0, then rd=0 must not write
        for (int s = 0; s < 8; s++) begin
            pc_i = 32'hFFFF_FFFC; npc_i = 32'h0; alu_result_i = 32'h1111_1111; Mem_rdata_i = 32'h2222_2222;
            sext_imm_i = 32'h3333_3333; rdata_csr_i = 32'h4444_4444; Gpr_Write_i = 1;
            Gpr_Write_Addr_i = 4'(s + 1); Gpr_Write_RD_i = 3'(s);
            go(1, 4'(s + 1), exp_sel[s], 32'h0, st);
        end
        pc_i = 32'h40; npc_i = 32'h44; Gpr_Write_i = 1; Gpr_Write_Addr_i = 0; alu_result_i = 32'h99;
        go(0, 4'd0, 32'h0, 32'h44, st);
        csr_chk("csr_unknown", 12'h123, 32'h0);
        align();
        // 3: set MIE, csrrw mtvec, then ecall
        pc_i = 32'h8000_0004; npc_i = 32'h8000_0008; Csr_Write_i = 1; Csr_Write_Addr_i = 12'h300;
        Csr_Write_RD_i = 1; rdata_csr_i = 32'h1800; rs1_data_i = 32'h8;
        go(0, 4'd0, 32'h0, 32'h8000_0008, st);
        pc_i = 32'h8000_0008; npc_i = 32'h8000_000C; Csr_Write_i = 1; Csr_Write_Addr_i = 12'h305;
        Csr_Write_RD_i = 0; rs1_data_i = 32'h8000_0103;
        go(0, 4'd0, 32'h0, 32'h8000_000C, st);
        csr_chk("mtvec_wr", 12'h305, 32'h8000_0100);
        csr_chk("mstatus_mie", 12'h300, 32'h1808);
        align();
        pc_i = 32'h8000_0010; npc_i = 32'h8000_0014; irq_i = 1; irq_no_i = 8'd11;
        Gpr_Write_i = 1; Gpr_Write_Addr_i = 3; alu_result_i = 32'hDEAD;
        go(0, 4'd0, 32'h0, 32'h8000_0100, st);
        chk("trap_flush", 64'({flush_o, redirect_valid, in_ready}), 64'b110);
        chk("trap_redirect_pc", 64'(redirect_pc), 64'h8000_0100);
        pc_i = 32'h8000_0100; npc_i = 32'h8000_0104; Gpr_Write_i = 1; Gpr_Write_Addr_i = 7; alu_result_i = 32'h77;
        go(1, 4'd7, 32'h77, 32'h8000_0104, st);
        chk("trap_stall_cycles", 64'(st), 1);
        chk("after_trap", 64'({flush_o, redirect_valid, in_ready}), 64'b001);
        csr_chk("mepc_trap", 12'h341, 32'h8000_0010);
        csr_chk("mcause_trap", 12'h342, 32'd11);
        csr_chk("mstatus_trap", 12'h300, 32'h1880);
        align();
        // 4: mret
        pc_i = 32'h8000_0104; npc_i = 32'h8000_0108; Csr_Write_i = 1; Csr_Write_Addr_i = 12'h341;
        rs1_data_i = 32'h8000_0040;
        go(0, 4'd0, 32'h0, 32'h8000_0108, st);
        pc_i = 32'h8000_0050; npc_i = 32'h8000_0054; is_mret_i = 1;
        go(0, 4'd0, 32'h0, 32'h8000_0040, st);
        chk("mret_flush", 64'({flush_o, redirect_valid, in_ready}), 64'b110);
        chk("mret_redirect_pc", 64'(redirect_pc), 64'h8000_0040);
        csr_chk("mstatus_mret", 12'h300, 32'h1888);
        csr_chk("minstret_16", 12'hB02, 32'd16);
        align();
        // 6: reset dropped during the TRAP cycle
        pc_i = 32'h200; npc_i = 32'h204; irq_i = 1; irq_no_i = 8'd3;
        go(0, 4'd0, 32'h0, 32'h8000_0100, st);
        chk("pre_rst_trap", 64'(flush_o), 1);
        in_valid = 1; Gpr_Write_i = 1; Gpr_Write_Addr_i = 5; alu_result_i = 32'h1;
        reset = 0;
        cq.delete();
        gq.delete();
        #1;
        chk("midtrap_rst_outs", 64'({flush_o, redirect_valid, commit_valid, halt_o, gpr_wen, in_ready}), 0);
        chk("midtrap_rst_pcs", {redirect_pc, commit_pc}, 0);
        chk("midtrap_rst_npc", 64'(commit_npc), 0);
        clr();
        align();
        reset = 1;
        #1;
        chk("rel2_in_ready", 64'(in_ready), 1);
        csr_chk("rel2_mstatus", 12'h300, 32'h1800);
        csr_chk("rel2_mepc", 12'h341, 32'h0);
        csr_chk("rel2_minstret", 12'hB02, 32'h0);
        align();
        chk("no_reflush", 64'({flush_o, redirect_valid}), 0);
        // 5: ten back-to-back accepts then ebreak
        for (int i = 0; i < 10; i++) begin
            pc_i = 32'h100 + 32'(4 * i); npc_i = pc_i + 4; Gpr_Write_i = 1;
            Gpr_Write_Addr_i = 4'(i % 15 + 1); alu_result_i = 32'(i * 3 + 1);
            go(1, 4'(i % 15 + 1), 32'(i * 3 + 1), 32'h104 + 32'(4 * i), st);
        end
        pc_i = 32'h128; npc_i = 32'h12C; is_break_i = 1;
        go(0, 4'd0, 32'h0, 32'h12C, st);
        chk("halt", 64'({halt_o, in_ready}), 64'b10);
        csr_chk("minstret_11", 12'hB02, 32'd11);
        csr_chk("minstret_hi", 12'hB82, 32'd0);
        in_valid = 1; Gpr_Write_i = 1; Gpr_Write_Addr_i = 2; alu_result_i = 32'h5;
        repeat (5) align();
        chk("halt_held", 64'({halt_o, in_ready, flush_o}), 64'b100);
        csr_chk("halt_minstret", 12'hB02, 32'd11);
        clr();
        repeat (2) align();
        chk("gq_drained", 64'(gq.size()), 0);
        chk("cq_drained", 64'(cq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end
endmodule
